// File: rtl/mem_load_arbiter.sv
// Shares the unified memory write/address port between the core MEM stage and a byte-stream
// program loader; holds the core while a load packs bytes little-endian into sequential words.
module mem_load_arbiter #(
    parameter int                    ADDR_WIDTH         = 32,
    parameter int                    WORD_WIDTH_IN_BYTE = 4,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE_ADDR     = '0,
    parameter int                    HOLD_RELEASE_DELAY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_load_start,
    input  logic [ADDR_WIDTH-1:0]           i_load_len,
    input  logic                            i_ld_valid,
    input  logic [7:0]                      i_ld_data,
    output logic                            o_ld_ready,
    output logic                            o_load_busy,
    output logic                            o_load_done,
    output logic                            o_core_hold,
    input  logic                            i_core_wr_en,
    input  logic [3:0]                      i_core_wr_width,
    input  logic [ADDR_WIDTH-1:0]           i_core_addr,
    input  logic [WORD_WIDTH_IN_BYTE*8-1:0] i_core_wr_data,
    output logic                            o_mem_wr_en,
    output logic [3:0]                      o_mem_wr_width,
    output logic [ADDR_WIDTH-1:0]           o_mem_addr,
    output logic [WORD_WIDTH_IN_BYTE*8-1:0] o_mem_wr_data,
    output logic                            o_err_core_wr
);

    localparam int DW     = WORD_WIDTH_IN_BYTE * 8;
    localparam int LANE_W = (WORD_WIDTH_IN_BYTE > 1) ? $clog2(WORD_WIDTH_IN_BYTE) : 1;
    localparam int CNT_W  = (HOLD_RELEASE_DELAY > 1) ? $clog2(HOLD_RELEASE_DELAY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_RELEASE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_len;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_byte_cnt;
    logic [DW-1:0]           r_buf;
    logic [CNT_W-1:0]        r_rel_cnt;
    logic                    r_load_done;
    logic                    r_err_core_wr;

    logic                    w_hs;
    logic [LANE_W-1:0]       w_lane;
    logic                    w_word_full;
    logic                    w_last_byte;
    logic                    w_rel_final;

    assign w_hs        = i_ld_valid && (r_state == S_COLLECT);
    assign w_lane      = r_byte_cnt[LANE_W-1:0];
    assign w_word_full = (w_lane == LANE_W'(WORD_WIDTH_IN_BYTE - 1));
    assign w_last_byte = ((r_byte_cnt + ADDR_WIDTH'(1)) == r_len);
    assign w_rel_final = (r_rel_cnt == CNT_W'(HOLD_RELEASE_DELAY - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_load_start && (i_load_len != '0)) w_next = S_COLLECT;
            S_COLLECT: if (w_hs && (w_word_full || w_last_byte)) w_next = S_WRITE;
            S_WRITE:   w_next = (r_byte_cnt == r_len) ? S_RELEASE : S_COLLECT;
            S_RELEASE: if (w_rel_final) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath registers; a zero-length request only produces the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len         <= '0;
            r_addr        <= '0;
            r_byte_cnt    <= '0;
            r_buf         <= '0;
            r_rel_cnt     <= '0;
            r_load_done   <= 1'b0;
            r_err_core_wr <= 1'b0;
        end else begin
            r_load_done   <= 1'b0;
            r_err_core_wr <= (r_state != S_IDLE) && i_core_wr_en;
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        if (i_load_len != '0) begin
                            r_len      <= i_load_len;
                            r_addr     <= LOAD_BASE_ADDR;
                            r_byte_cnt <= '0;
                            r_buf      <= '0;
                            r_rel_cnt  <= '0;
                        end else begin
                            r_load_done <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_hs) begin
                        r_buf[{w_lane, 3'b000} +: 8] <= i_ld_data;
                        r_byte_cnt <= r_byte_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    r_addr    <= r_addr + ADDR_WIDTH'(WORD_WIDTH_IN_BYTE);
                    r_buf     <= '0;
                    r_rel_cnt <= '0;
                end
                S_RELEASE: begin
                    r_rel_cnt <= r_rel_cnt + CNT_W'(1);
                    if (w_rel_final) r_load_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Idle is a zero-latency pass-through; otherwise the loader owns the port.
    always_comb begin
        o_ld_ready     = 1'b0;
        o_mem_wr_en    = 1'b0;
        o_mem_wr_width = 4'(WORD_WIDTH_IN_BYTE);
        o_mem_addr     = r_addr;
        o_mem_wr_data  = r_buf;
        case (r_state)
            S_IDLE: begin
                o_mem_wr_en    = i_core_wr_en;
                o_mem_wr_width = i_core_wr_width;
                o_mem_addr     = i_core_addr;
                o_mem_wr_data  = i_core_wr_data;
            end
            S_COLLECT: o_ld_ready  = 1'b1;
            S_WRITE:   o_mem_wr_en = 1'b1;
            default: ;
        endcase
    end

    assign o_load_busy   = (r_state != S_IDLE);
    assign o_core_hold   = (r_state != S_IDLE);
    assign o_load_done   = r_load_done;
    assign o_err_core_wr = r_err_core_wr;

endmodule
